// File: rtl/tagged_iter_divider_pkg.sv
// Shared definitions for the tagged iterative divider: sub-op encodings and FSM states.
package div_pkg;

  localparam logic [2:0] DIV_OP  = 3'b100;
  localparam logic [2:0] DIVU_OP = 3'b101;
  localparam logic [2:0] REM_OP  = 3'b110;
  localparam logic [2:0] REMU_OP = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/tagged_iter_divider_if.sv
// Request/result bundle between the divide reservation station, the divider and the CDB arbiter.
interface tagged_iter_divider_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  // Request: accepted on a cycle with start_i & ready_o & sub_op[2] & ~flush_i.
  // Result: valid_o/tag_o/result_o stay stable until a cycle with valid_o & out_ready_i.
  logic             flush_i;
  logic             start_i;
  logic [2:0]       sub_op;
  logic [XLEN-1:0]  op1;
  logic [XLEN-1:0]  op2;
  logic [TAG_W-1:0] tag_i;
  logic             ready_o;
  logic             valid_o;
  logic [TAG_W-1:0] tag_o;
  logic [XLEN-1:0]  result_o;
  logic             out_ready_i;

  modport master (
    output flush_i, start_i, sub_op, op1, op2, tag_i, out_ready_i,
    input  ready_o, valid_o, tag_o, result_o
  );

  modport slave (
    input  flush_i, start_i, sub_op, op1, op2, tag_i, out_ready_i,
    output ready_o, valid_o, tag_o, result_o
  );
endinterface

// File: rtl/tagged_iter_divider_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module lzc #(
  parameter int W = 32
) (
  input  logic [W-1:0]       a,
  output logic [$clog2(W):0] cnt
);
  localparam int CW = $clog2(W) + 1;

  logic found;

  always_comb begin
    cnt   = CW'(W);
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && a[i]) begin
        cnt   = CW'(W - 1 - i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tagged_iter_divider.sv
// Iterative radix-2 non-restoring divider with ROB tags, output backpressure, flush abort,
// leading-zero early-out and a one-entry result-reuse cache.
module tagged_iter_divider
  import div_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 5,
  parameter int EARLY_OUT = 1,
  parameter int REUSE     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  tagged_iter_divider_if.slave   bus,
  output div_state_e             state_dbg
);
  localparam int LZW = $clog2(XLEN) + 1;

  div_state_e       state_q, state_d;
  logic             accept, in_signed, in_rem, a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag, spec_res, hit_res;
  logic [LZW-1:0]   lz_raw, lz;
  logic             is_div0, is_ovf, is_zero, special, hit;

  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  res_q, op1_q, op2_q, d_q, quo_q;
  logic [XLEN:0]    r_q;
  logic [LZW-1:0]   cnt_q;
  logic             sgn_q, rem_q, a_neg_q, b_neg_q;

  logic             c_valid, c_sgn;
  logic [XLEN-1:0]  c_op1, c_op2, c_quo, c_rem;

  logic [XLEN:0]    r_sh, r_step;
  logic [XLEN-1:0]  q_step, r_fix;

  function automatic logic [XLEN-1:0] fix_sign(input logic rem_sel, input logic an, input logic bn,
                                               input logic [XLEN-1:0] q, input logic [XLEN-1:0] r);
    if (rem_sel) return an ? -r : r;
    return (an ^ bn) ? -q : q;
  endfunction

  assign bus.ready_o  = (state_q == IDLE);
  assign bus.valid_o  = (state_q == DONE);
  assign bus.tag_o    = tag_q;
  assign bus.result_o = res_q;
  assign state_dbg    = state_q;

  assign accept    = bus.start_i & bus.ready_o & bus.sub_op[2] & ~bus.flush_i;
  assign in_signed = ~bus.sub_op[0];
  assign in_rem    = bus.sub_op[1];
  assign a_neg     = in_signed & bus.op1[XLEN-1];
  assign b_neg     = in_signed & bus.op2[XLEN-1];
  assign a_mag     = a_neg ? -bus.op1 : bus.op1;
  assign b_mag     = b_neg ? -bus.op2 : bus.op2;

  lzc #(.W(XLEN)) u_lzc (.a(a_mag), .cnt(lz_raw));
  assign lz = (EARLY_OUT != 0) ? lz_raw : '0;

  assign is_div0 = (bus.op2 == '0);
  assign is_ovf  = in_signed & (bus.op1 == {1'b1, {(XLEN-1){1'b0}}}) & (bus.op2 == '1);
  assign is_zero = (a_mag == '0);
  assign special = is_div0 | is_ovf | is_zero;
  assign hit     = (REUSE != 0) & c_valid & (bus.op1 == c_op1) & (bus.op2 == c_op2) &
                   (in_signed == c_sgn);
  assign hit_res = fix_sign(in_rem, a_neg, b_neg, c_quo, c_rem);

  always_comb begin
    spec_res = '0;
    if (is_div0)     spec_res = in_rem ? bus.op1 : '1;
    else if (is_ovf) spec_res = in_rem ? '0 : bus.op1;
  end

  // One non-restoring step; the quotient bit is the complement of the new remainder sign.
  assign r_sh   = {r_q[XLEN-1:0], quo_q[XLEN-1]};
  assign r_step = r_q[XLEN] ? r_sh + {1'b0, d_q} : r_sh - {1'b0, d_q};
  assign q_step = {quo_q[XLEN-2:0], ~r_step[XLEN]};
  assign r_fix  = r_q[XLEN-1:0] + (r_q[XLEN] ? d_q : '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = (special | hit) ? DONE : CALC;
        CALC:    if (cnt_q == LZW'(1)) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    if (bus.out_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q   <= '0;
      res_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      rem_q   <= 1'b0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      c_valid <= 1'b0;
      c_sgn   <= 1'b0;
      c_op1   <= '0;
      c_op2   <= '0;
      c_quo   <= '0;
      c_rem   <= '0;
    end else begin
      if (accept) begin
        tag_q   <= bus.tag_i;
        sgn_q   <= in_signed;
        rem_q   <= in_rem;
        a_neg_q <= a_neg;
        b_neg_q <= b_neg;
        op1_q   <= bus.op1;
        op2_q   <= bus.op2;
        d_q     <= b_mag;
        quo_q   <= a_mag << lz;
        r_q     <= '0;
        cnt_q   <= LZW'(XLEN) - lz;
        if (special)  res_q <= spec_res;
        else if (hit) res_q <= hit_res;
      end
      if (state_q == CALC) begin
        r_q   <= r_step;
        quo_q <= q_step;
        cnt_q <= cnt_q - LZW'(1);
      end
      // An op flushed in FIX is abandoned, so it must not leave a cache entry behind.
      if (state_q == FIX && !bus.flush_i) begin
        res_q   <= fix_sign(rem_q, a_neg_q, b_neg_q, quo_q, r_fix);
        c_valid <= 1'b1;
        c_sgn   <= sgn_q;
        c_op1   <= op1_q;
        c_op2   <= op2_q;
        c_quo   <= quo_q;
        c_rem   <= r_fix;
      end
    end
  end
endmodule
